// File: rtl/store_buffer_ctrl.sv
// Posted-write store buffer and single-ported data-memory scheduler.
// Stores retire in one cycle and drain in the background; loads and fences are ordered against them.
module store_buffer_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_fence,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_wstrb,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, FENCE} state_t;

  // Handshake: a request is taken in the cycle req_valid && req_ready;
  // a memory transaction completes in the cycle mem_valid && mem_ready.

  state_t           state_q, state_d;
  logic [31:0]      addr_mem  [DEPTH];
  logic [31:0]      wdata_mem [DEPTH];
  logic [3:0]       wstrb_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    head_q, tail_q;
  logic             fence_pending_q;

  logic is_store, is_load, is_fence, full, hazard, mem_done;
  logic store_acc, load_acc, fence_acc, issue_drain, drain_done, load_done;
  logic set_fence, clr_fence;

  assign is_store = req_valid && !req_fence && (req_wstrb != 4'd0);
  assign is_load  = req_valid && !req_fence && (req_wstrb == 4'd0);
  assign is_fence = req_valid && req_fence;
  assign full     = (sb_count == CW'(DEPTH));
  assign mem_done = mem_valid && mem_ready;
  assign sb_empty = (sb_count == '0) && (state_q == IDLE);

  // Word-granular address match against every occupied entry, including the one draining.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_mem[i][31:2] == req_addr[31:2])) hazard = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_acc   = is_store && !full && !fence_pending_q;
    load_acc    = 1'b0;
    fence_acc   = 1'b0;
    issue_drain = 1'b0;
    drain_done  = 1'b0;
    load_done   = 1'b0;
    set_fence   = 1'b0;
    clr_fence   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load && !hazard) begin
          load_acc = 1'b1;
          state_d  = LOAD;
        end else if (is_fence && (sb_count == '0)) begin
          fence_acc = 1'b1;
        end else if (is_fence) begin
          set_fence = 1'b1;
          state_d   = FENCE;
        end else if (sb_count != '0) begin
          issue_drain = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) begin
          drain_done = 1'b1;
          state_d    = fence_pending_q ? FENCE : IDLE;
        end
      end
      LOAD: begin
        if (mem_done) begin
          load_done = 1'b1;
          state_d   = IDLE;
        end
      end
      FENCE: begin
        if (sb_count == '0) begin
          if (is_fence) begin
            fence_acc = 1'b1;
            clr_fence = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          issue_drain = 1'b1;
          state_d     = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready = store_acc || load_acc || fence_acc;
  end

  // Entry payload needs no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      addr_mem[tail_q]  <= req_addr;
      wdata_mem[tail_q] <= req_wdata;
      wstrb_mem[tail_q] <= req_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      sb_count        <= '0;
      fence_pending_q <= 1'b0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      mem_valid       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wstrb       <= '0;
    end else begin
      state_q <= state_d;
      if (store_acc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + AW'(1);
      end
      if (drain_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + AW'(1);
      end
      case ({store_acc, drain_done})
        2'b10:   sb_count <= sb_count + CW'(1);
        2'b01:   sb_count <= sb_count - CW'(1);
        default: sb_count <= sb_count;
      endcase
      if (set_fence)      fence_pending_q <= 1'b1;
      else if (clr_fence) fence_pending_q <= 1'b0;
      resp_valid <= store_acc || fence_acc || load_done;
      if (load_done) resp_rdata <= mem_rdata;
      if (load_acc) begin
        mem_valid <= 1'b1;
        mem_addr  <= req_addr;
        mem_wdata <= '0;
        mem_wstrb <= 4'd0;
      end else if (issue_drain) begin
        mem_valid <= 1'b1;
        mem_addr  <= addr_mem[head_q];
        mem_wdata <= wdata_mem[head_q];
        mem_wstrb <= wstrb_mem[head_q];
      end else if (mem_done) begin
        mem_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Directed bench for store_buffer_ctrl: buffering, FIFO drain, load hazard and priority,
// fences and mid-transaction reset, with hand-computed expectations.
module tb_store_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_fence;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int tests  = 0;
  int failed = 0;

  logic [31:0] exp_a [4] = '{32'h104, 32'h108, 32'h10C, 32'h110};
  logic [31:0] exp_d [4] = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
  logic [3:0]  exp_s [4] = '{4'hF, 4'h3, 4'hC, 4'hF};

  store_buffer_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_fence(req_fence), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_fence = 1'b0; req_addr = a; req_wdata = d; req_wstrb = s;
    #1;
    check("store_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_wstrb = 4'd0;
    check("store_resp", 32'(resp_valid), 32'd1);
  endtask

  task automatic present_load(input logic [31:0] a);
    req_valid = 1'b1; req_fence = 1'b0; req_addr = a; req_wdata = '0; req_wstrb = 4'd0;
    #1;
  endtask

  task automatic present_fence();
    req_valid = 1'b1; req_fence = 1'b1; req_addr = '0; req_wdata = '0; req_wstrb = 4'd0;
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; req_valid = 1'b0; req_fence = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = 4'd0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_sb_count", 32'(sb_count), 32'd0);
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    rst = 1'b1;
    tick();

    // Fill the buffer with memory stalled.
    do_store(32'h100, 32'h11111111, 4'hF);
    do_store(32'h104, 32'h22222222, 4'hF);
    do_store(32'h108, 32'h33333333, 4'h3);
    do_store(32'h10C, 32'h44444444, 4'hC);
    check("full_count", 32'(sb_count), 32'd4);
    check("drain0_valid", 32'(mem_valid), 32'd1);
    check("drain0_addr", mem_addr, 32'h100);
    check("drain0_wdata", mem_wdata, 32'h11111111);
    check("drain0_wstrb", 32'(mem_wstrb), 32'hF);

    req_valid = 1'b1; req_fence = 1'b0; req_addr = 32'h110; req_wdata = 32'h55555555; req_wstrb = 4'hF;
    #1;
    check("full_stall", 32'(req_ready), 32'd0);
    tick(); tick();
    check("full_stall2", 32'(req_ready), 32'd0);
    check("drain0_hold", mem_addr, 32'h100);
    mem_ready = 1'b1;
    tick();
    check("after_drain0_ready", 32'(req_ready), 32'd1);
    check("after_drain0_count", 32'(sb_count), 32'd3);
    check("after_drain0_mem_valid", 32'(mem_valid), 32'd0);
    tick();
    req_valid = 1'b0; req_wstrb = 4'd0;
    check("store5_resp", 32'(resp_valid), 32'd1);
    check("store5_count", 32'(sb_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", 32'(mem_valid), 32'd1);
      check("drain_addr", mem_addr, exp_a[k]);
      check("drain_wdata", mem_wdata, exp_d[k]);
      check("drain_wstrb", 32'(mem_wstrb), 32'(exp_s[k]));
      tick();
      check("drain_gap", 32'(mem_valid), 32'd0);
      check("drain_count", 32'(sb_count), 32'(3 - k));
      if (k < 3) tick();
    end
    check("drained_empty", 32'(sb_empty), 32'd1);

    // Load hazard against a buffered store.
    mem_ready = 1'b0;
    do_store(32'h200, 32'hDEADBEEF, 4'hF);
    present_load(32'h202);
    check("hazard_stall", 32'(req_ready), 32'd0);
    tick();
    check("hazard_drain_addr", mem_addr, 32'h200);
    check("hazard_drain_wdata", mem_wdata, 32'hDEADBEEF);
    check("hazard_stall2", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    check("hazard_clear", 32'(req_ready), 32'd1);
    check("hazard_count", 32'(sb_count), 32'd0);
    mem_rdata = 32'hCAFEF00D;
    tick();
    req_valid = 1'b0;
    check("load_mem_valid", 32'(mem_valid), 32'd1);
    check("load_mem_addr", mem_addr, 32'h202);
    check("load_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("load_no_early_resp", 32'(resp_valid), 32'd0);
    tick();
    check("load_resp", 32'(resp_valid), 32'd1);
    check("load_rdata", resp_rdata, 32'hCAFEF00D);
    tick();
    check("load_resp_pulse", 32'(resp_valid), 32'd0);

    // A clean load beats pending drains.
    mem_ready = 1'b0;
    do_store(32'h100, 32'hAAAA0001, 4'hF);
    do_store(32'h104, 32'hAAAA0002, 4'hF);
    do_store(32'h108, 32'hAAAA0003, 4'hF);
    mem_rdata = 32'h12345678;
    present_load(32'h300);
    check("prio_busy", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    check("prio_ready", 32'(req_ready), 32'd1);
    check("prio_count", 32'(sb_count), 32'd2);
    tick();
    req_valid = 1'b0;
    check("prio_load_addr", mem_addr, 32'h300);
    check("prio_load_wstrb", 32'(mem_wstrb), 32'd0);
    tick();
    check("prio_resp", 32'(resp_valid), 32'd1);
    check("prio_rdata", resp_rdata, 32'h12345678);
    tick();
    check("prio_drain1_addr", mem_addr, 32'h104);
    check("prio_drain1_wdata", mem_wdata, 32'hAAAA0002);
    tick(); tick();
    check("prio_drain2_addr", mem_addr, 32'h108);
    tick();
    check("prio_done_count", 32'(sb_count), 32'd0);

    // Fence on an empty buffer completes at once.
    present_fence();
    check("fence_empty_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_fence = 1'b0;
    check("fence_empty_resp", 32'(resp_valid), 32'd1);

    // Fence with three buffered stores.
    mem_ready = 1'b0;
    do_store(32'h400, 32'hBBBB0001, 4'hF);
    do_store(32'h404, 32'hBBBB0002, 4'hF);
    do_store(32'h408, 32'hBBBB0003, 4'hF);
    check("fence_fill_count", 32'(sb_count), 32'd3);
    present_fence();
    check("fence_wait0", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    check("fence_wait1", 32'(req_ready), 32'd0);
    tick();
    check("fence_pending_count", 32'(sb_count), 32'd2);
    check("fence_pending_empty", 32'(sb_empty), 32'd0);
    req_fence = 1'b0; req_addr = 32'h40C; req_wdata = 32'hBBBB0004; req_wstrb = 4'hF;
    #1;
    check("fence_blocks_store", 32'(req_ready), 32'd0);
    req_fence = 1'b1; req_addr = '0; req_wdata = '0; req_wstrb = 4'd0;
    #1;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    check("fence_ready", 32'(req_ready), 32'd1);
    check("fence_latency", 32'(n), 32'd4);
    check("fence_ready_count", 32'(sb_count), 32'd0);
    check("fence_ready_not_idle", 32'(sb_empty), 32'd0);
    tick();
    req_valid = 1'b0; req_fence = 1'b0;
    check("fence_resp", 32'(resp_valid), 32'd1);
    check("fence_done_empty", 32'(sb_empty), 32'd1);

    // Reset in the middle of a drain.
    mem_ready = 1'b0;
    do_store(32'h500, 32'hC0000001, 4'hF);
    do_store(32'h504, 32'hC0000002, 4'hF);
    check("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_count", 32'(sb_count), 32'd0);
    check("mid_rst_empty", 32'(sb_empty), 32'd1);
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    tick();
    present_load(32'h500);
    check("post_rst_no_hazard", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
